// File: rtl/serial_pattern_generator.sv
// ----------------------------------------------------------------------------
// serial_pattern_generator
//   Parallel-load, serial-out pulse/pattern generator. A WIDTH-bit pattern and
//   its bit length are accepted over a valid/ready handshake and then emitted
//   one bit per bit period on 'out', MSB- or LSB-first, once or repeatedly.
//
//   Optional feature macro: SPG_PRESCALE_EN
//     defined   -> each bit is held for BIT_CYCLES clocks (prescale counter)
//     undefined -> each bit is held for exactly one clock; BIT_CYCLES unused
//
// Ports
//   clock        in   1       system clock, rising edge
//   reset_n      in   1       asynchronous active-low reset
//   load_valid   in   1       pattern offer
//   load_ready   out  1       pattern can be accepted (registered, IDLE only)
//   load_data    in   WIDTH   pattern bits
//   load_len     in   LW      bits to emit; 0 or >WIDTH means WIDTH
//   repeat_mode  in   1       sampled at accept: loop pattern until abort
//   abort        in   1       synchronous stop request
//   out          out  1       serial output (registered)
//   busy         out  1       high while emitting
//   done         out  1       one-cycle pulse after a one-shot pattern ends
// ----------------------------------------------------------------------------
module serial_pattern_generator #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [WIDTH-1:0]             load_data,
    input  logic [$clog2(WIDTH+1)-1:0]   load_len,
    input  logic                         repeat_mode,
    input  logic                         abort,
    output logic                         out,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned   LW       = $clog2(WIDTH + 1);
    localparam logic [LW-1:0] FULL_LEN = LW'(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pat_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    bitcnt_q;
    logic             rep_q;
    logic             out_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;

    logic [LW-1:0]    len_d;        // effective length of the offered pattern
    logic             first_d;      // first bit of the offered pattern
    logic             next_bit_d;   // bit following the current one
    logic             first_cap_d;  // first bit of the captured pattern
    logic             accept;
    logic             last_bit;
    logic             bit_end;

    // Bit at emission position i of a pattern of length l. A shift is used
    // instead of a variable bit-select so the index width never matters.
    function automatic logic pick(input logic [WIDTH-1:0] p,
                                  input logic [LW-1:0]    l,
                                  input logic [LW-1:0]    i);
        logic [LW-1:0]    idx;
        logic [WIDTH-1:0] sh;
        idx = MSB_FIRST ? (l - LW'(1) - i) : i;
        sh  = p >> idx;
        return sh[0];
    endfunction

    always_comb begin
        len_d       = ((load_len == '0) || (load_len > FULL_LEN)) ? FULL_LEN : load_len;
        first_d     = pick(load_data, len_d, '0);
        next_bit_d  = pick(pat_q, len_q, bitcnt_q + LW'(1));
        first_cap_d = pick(pat_q, len_q, '0);
        accept      = (state_q == S_IDLE) && load_valid && !abort;
        last_bit    = (bitcnt_q == (len_q - LW'(1)));
    end

`ifdef SPG_PRESCALE_EN
    localparam int unsigned PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [PW-1:0] presc_q;

    assign bit_end = (presc_q == PW'(BIT_CYCLES - 1));

    // Held at zero outside SHIFT so every pattern starts a fresh bit period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else if ((state_q != S_SHIFT) || abort || bit_end) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end
`else
    // Every clock ends a bit; BIT_CYCLES has no effect without the prescaler.
    assign bit_end = (BIT_CYCLES != 0) || 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            bitcnt_q <= '0;
            rep_q    <= 1'b0;
            out_q    <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        pat_q    <= load_data;
                        len_q    <= len_d;
                        rep_q    <= repeat_mode;
                        bitcnt_q <= '0;
                        out_q    <= first_d;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        bitcnt_q <= '0;
                        out_q    <= IDLE_LEVEL;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end else if (bit_end) begin
                        if (last_bit) begin
                            bitcnt_q <= '0;
                            if (rep_q) begin
                                out_q <= first_cap_d;
                            end else begin
                                out_q   <= IDLE_LEVEL;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                ready_q <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + LW'(1);
                            out_q    <= next_bit_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out        = out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// ----------------------------------------------------------------------------
// tb_serial_pattern_generator
//   Drives an MSB-first and an LSB-first instance with shared stimulus and
//   compares both against a behavioural model that expands each accepted
//   pattern into its full per-clock output sequence.
// ----------------------------------------------------------------------------
module tb_serial_pattern_generator;

`ifdef SPG_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        load_valid  = 1'b0;
    logic [15:0] load_data   = '0;
    logic [4:0]  load_len    = '0;
    logic        repeat_mode = 1'b0;
    logic        abort       = 1'b0;

    logic out_m, busy_m, done_m, ready_m;
    logic out_l, busy_l, done_l, ready_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    serial_pattern_generator #(
        .WIDTH(16), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .BIT_CYCLES(4)
    ) dut_m (
        .clock(clock), .reset_n(reset_n),
        .load_valid(load_valid), .load_ready(ready_m),
        .load_data(load_data), .load_len(load_len),
        .repeat_mode(repeat_mode), .abort(abort),
        .out(out_m), .busy(busy_m), .done(done_m)
    );

    serial_pattern_generator #(
        .WIDTH(16), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .BIT_CYCLES(4)
    ) dut_l (
        .clock(clock), .reset_n(reset_n),
        .load_valid(load_valid), .load_ready(ready_l),
        .load_data(load_data), .load_len(load_len),
        .repeat_mode(repeat_mode), .abort(abort),
        .out(out_l), .busy(busy_l), .done(done_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = MSB-first instance, 1 = LSB-first instance.
    // m_seq holds the whole per-clock output sequence of the active pattern.
    int m_seq [2][64];
    int m_n   [2];
    int m_pos [2];
    bit m_rep [2];
    bit m_busy[2];
    bit m_done[2];
    bit m_out [2];

    task automatic model_step(input int k);
        int L;
        int src;
        m_done[k] = 1'b0;
        if (m_busy[k]) begin
            if (abort) begin
                m_busy[k] = 1'b0;
                m_out[k]  = 1'b0;
            end else if (m_pos[k] + 1 < m_n[k]) begin
                m_pos[k]++;
                m_out[k] = m_seq[k][m_pos[k]][0];
            end else if (m_rep[k]) begin
                m_pos[k] = 0;
                m_out[k] = m_seq[k][0][0];
            end else begin
                m_busy[k] = 1'b0;
                m_done[k] = 1'b1;
                m_out[k]  = 1'b0;
            end
        end else if (load_valid && !abort) begin
            L = (load_len == 0 || load_len > 16) ? 16 : int'(load_len);
            for (int b = 0; b < L; b++) begin
                src = (k == 0) ? (L - 1 - b) : b;
                for (int c = 0; c < P; c++) m_seq[k][b*P + c] = int'(load_data[src]);
            end
            m_n[k]    = L * P;
            m_pos[k]  = 0;
            m_rep[k]  = repeat_mode;
            m_busy[k] = 1'b1;
            m_out[k]  = m_seq[k][0][0];
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_out[k]  = 1'b0;
                m_pos[k]  = 0;
                m_n[k]    = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    always @(negedge clock) begin
        check("out_m",   out_m,   m_out[0]);
        check("busy_m",  busy_m,  m_busy[0]);
        check("done_m",  done_m,  m_done[0]);
        check("ready_m", ready_m, !m_busy[0]);
        check("out_l",   out_l,   m_out[1]);
        check("busy_l",  busy_l,  m_busy[1]);
        check("done_l",  done_l,  m_done[1]);
        check("ready_l", ready_l, !m_busy[1]);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [15:0] d, input logic [4:0] l, input logic r);
        load_valid  = 1'b1;
        load_data   = d;
        load_len    = l;
        repeat_mode = r;
    endtask

    initial begin : stim
        logic [15:0] cap16;
        logic [8:0]  cap9;
        logic [7:0]  cap8;
        logic [4:0]  s5, d5;
        logic [3:0]  cap4;
        int          busy_cnt;

        #1 reset_n = 1'b0;
        #1;
        check("rst_out",   out_m,   1'b0);
        check("rst_busy",  busy_m,  1'b0);
        check("rst_done",  done_m,  1'b0);
        check("rst_ready", ready_m, 1'b1);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

`ifndef SPG_PRESCALE_EN
        // One-shot, len=0 means full width; later data changes are ignored.
        offer(16'hA5F0, 5'd0, 1'b0);
        tick();
        load_valid = 1'b0;
        load_data  = 16'hFFFF;
        busy_cnt   = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            cap16[15-i] = out_m;
            busy_cnt += int'(busy_m);
        end
        check("t2_pattern", cap16, 16'hA5F0);
        check("t2_busy_len", busy_cnt, 16);
        @(negedge clock);
        check("t2_done", done_m, 1'b1);
        check("t2_idle_out", out_m, 1'b0);
        @(negedge clock);
        check("t2_done_once", done_m, 1'b0);

        // LSB-first, len=4: only bits [3:0] of 0x0006 appear.
        offer(16'h0006, 5'd4, 1'b0);
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            cap4[i] = out_l;
        end
        check("t3_lsb_seq", cap4, 4'b0110);
        @(negedge clock);
        check("t3_idle_out", out_l, 1'b0);
        check("t3_done", done_l, 1'b1);

        // Repeat mode then abort.
        offer(16'h0005, 5'd3, 1'b1);
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            cap9[8-i] = out_m;
        end
        check("t4_repeat_seq", cap9, 9'b101101101);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clock);
        check("t4_abort_out", out_m, 1'b0);
        check("t4_abort_busy", busy_m, 1'b0);
        check("t4_abort_done", done_m, 1'b0);
        check("t4_abort_ready", ready_m, 1'b1);

        // Abort beats load in IDLE; offers while busy are ignored;
        // a load in the done cycle leaves exactly one idle cycle.
        abort = 1'b1;
        offer(16'h0003, 5'd2, 1'b0);
        tick();
        check("t6_no_accept_ready", ready_m, 1'b1);
        check("t6_no_accept_busy", busy_m, 1'b0);
        abort = 1'b0;
        tick();
        load_data = 16'h0000;
        load_len  = 5'd5;
        @(negedge clock); s5[4] = out_m; d5[4] = done_m;
        tick();
        @(negedge clock); s5[3] = out_m; d5[3] = done_m;
        tick();
        load_data = 16'h0003;
        load_len  = 5'd2;
        @(negedge clock); s5[2] = out_m; d5[2] = done_m;
        tick();
        load_valid = 1'b0;
        @(negedge clock); s5[1] = out_m; d5[1] = done_m;
        @(negedge clock); s5[0] = out_m; d5[0] = done_m;
        check("t6_b2b_out", s5, 5'b11011);
        check("t6_b2b_done", d5, 5'b00100);
`else
        // Prescaled: each bit is held for four clocks.
        offer(16'h0002, 5'd2, 1'b0);
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            cap8[7-i] = out_m;
        end
        check("t5_prescale_seq", cap8, 8'hF0);
        @(negedge clock);
        check("t5_done", done_m, 1'b1);
`endif

        // Asynchronous reset in the middle of a repeating pattern.
        tick();
        offer(16'hA5F0, 5'd0, 1'b1);
        tick();
        load_valid = 1'b0;
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        check("t1_async_out",   out_m,   1'b0);
        check("t1_async_busy",  busy_m,  1'b0);
        check("t1_async_done",  done_m,  1'b0);
        check("t1_async_ready", ready_m, 1'b1);
        check("t1_async_busy_l", busy_l, 1'b0);
        tick();
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            load_valid  = ($urandom_range(0, 2) == 0);
            abort       = ($urandom_range(0, 15) == 0);
            load_data   = 16'($urandom);
            load_len    = 5'($urandom_range(0, 31));
            repeat_mode = ($urandom_range(0, 3) == 0);
            tick();
        end
        load_valid = 1'b0;
        abort      = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
